// File: rtl/ln_calc.sv
// Iterative natural-log unit: normalises a Q15.11 operand by left shifts, then
// refines the fraction with shift-and-add factors (1 + 2^-i), giving ln(x) in Q4.11.
module ln_calc #(
    parameter int N_ITER = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [25:0] x,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [14:0] result
);

    localparam logic [18:0] ACC_INIT  = 19'd340695;   // 15*ln2 in Q4.15
    localparam logic [18:0] LN2       = 19'd22713;
    localparam logic [3:0]  LAST_ITER = 4'(N_ITER);

    typedef enum logic [1:0] {IDLE, NORM, ITER, DONE} state_t;

    state_t      state;
    logic [25:0] m;
    logic [15:0] mant;
    logic [18:0] acc;
    logic [3:0]  i;
    logic        invalid;
    logic [16:0] t;

    // ln(1 + 2^-idx) in Q0.15, rounded to nearest
    function automatic logic [18:0] lnt(input logic [3:0] idx);
        logic [18:0] v;
        case (idx)
            4'd1:    v = 19'd13286;
            4'd2:    v = 19'd7312;
            4'd3:    v = 19'd3860;
            4'd4:    v = 19'd1987;
            4'd5:    v = 19'd1008;
            4'd6:    v = 19'd508;
            4'd7:    v = 19'd255;
            4'd8:    v = 19'd128;
            4'd9:    v = 19'd64;
            4'd10:   v = 19'd32;
            default: v = 19'd0;
        endcase
        return v;
    endfunction

    // Q4.15 -> Q4.11 with round-half-up
    function automatic logic [14:0] round_result(input logic [18:0] a);
        logic [19:0] s;
        s = {1'b0, a} + 20'd8;
        return s[18:4];
    endfunction

    always_comb begin
        t = {1'b0, mant} + ({1'b0, mant} >> i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            result  <= 15'd0;
            m       <= 26'd0;
            mant    <= 16'd0;
            acc     <= 19'd0;
            i       <= 4'd0;
            invalid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        m    <= x;
                        acc  <= ACC_INIT;
                        i    <= 4'd1;
                        busy <= 1'b1;
                        if (x[25:11] == 15'd0) begin
                            invalid <= 1'b1;
                            state   <= DONE;
                        end else begin
                            invalid <= 1'b0;
                            state   <= NORM;
                        end
                    end
                end
                NORM: begin
                    if (!m[25]) begin
                        m   <= {m[24:0], 1'b0};
                        acc <= acc - LN2;
                    end else begin
                        mant  <= m[25:10];
                        state <= ITER;
                    end
                end
                ITER: begin
                    // accept a factor only while the mantissa stays below 2.0
                    if (!t[16]) begin
                        mant <= t[15:0];
                        acc  <= acc - lnt(i);
                    end
                    i <= i + 4'd1;
                    if (i == LAST_ITER) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (invalid) begin
                        result <= 15'd0;
                        err    <= 1'b1;
                    end else begin
                        result <= round_result(acc);
                        err    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ln_calc.sv
// Bench for ln_calc: random and directed operands checked cycle by cycle against
// an arithmetic model of the log decomposition.
module tb_ln_calc;

    localparam int N_ITER = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [25:0] x = 26'd0;
    logic        busy;
    logic        done;
    logic        err;
    logic [14:0] result;

    ln_calc #(.N_ITER(N_ITER)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .x      (x),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .result (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    int lnt_tab [1:10] = '{13286, 7312, 3860, 1987, 1008, 508, 255, 128, 64, 32};

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_near(input string name, input longint act, input longint exp, input longint tol);
        longint d;
        checks++;
        d = (act > exp) ? act - exp : exp - act;
        if (d > tol) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
        end
    endtask

    // ln(x) = 14ln2 - c*ln2 + ln(M), ln(M) = ln2 - sum of accepted ln(1+2^-s)
    function automatic void model(input logic [25:0] xv, output int k, output int res, output bit e);
        int c;
        int mant;
        int acc;
        int tt;
        if (xv < 26'h800) begin
            k = 1; res = 0; e = 1'b1;
            return;
        end
        c = 0;
        while (xv[25 - c] == 1'b0) c++;
        mant = int'(xv) * (1 << c) / 1024;
        acc = 340695 - c * 22713;
        for (int s = 1; s <= N_ITER; s++) begin
            tt = mant + (mant >> s);
            if (tt < 65536) begin
                mant = tt;
                acc -= lnt_tab[s];
            end
        end
        acc = acc & 32'h7FFFF;
        res = ((acc + 8) >> 4) & 32'h7FFF;
        k = c + 12;
        e = 1'b0;
    endfunction

    // Scoreboard state: at most one operation in flight
    bit pend = 1'b0;
    int p_done = 0;
    int p_res = 0;
    bit p_err = 1'b0;
    int exp_res = 0;
    bit exp_err = 1'b0;

    always @(negedge clk) begin
        bit ed;
        bit eb;
        int k;
        int r;
        bit e;
        if (!rst_n) begin
            pend = 1'b0;
            exp_res = 0;
            exp_err = 1'b0;
        end
        ed = pend && (cyc == p_done);
        eb = pend && (cyc < p_done);
        chk("done", done, ed);
        chk("busy", busy, eb);
        if (ed) begin
            exp_res = p_res;
            exp_err = p_err;
            pend = 1'b0;
        end
        chk("result", result, exp_res);
        chk("err", err, exp_err);
        if (rst_n && start && !eb) begin
            model(x, k, r, e);
            pend = 1'b1;
            p_done = cyc + 1 + k;
            p_res = r;
            p_err = e;
        end
    end

    task automatic pulse_start(input logic [25:0] xv);
        @(posedge clk);
        #1;
        x = xv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        x = 26'($urandom);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((pend || busy) && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk(name, (n < 80), 1);
    endtask

    logic [25:0] dir_x [8] = '{26'h0000800, 26'h0001000, 26'h00015BF, 26'h2000000,
                               26'h0000400, 26'h0000000, 26'h0000800, 26'h3FFFFFF};

    initial begin
        int k;
        int r;
        bit e;
        logic [25:0] rx;
        int w;

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        model(26'h0000800, k, r, e);
        chk_near("pin_1p0_res", r, 0, 3);
        chk("pin_1p0_lat", k, 26);
        model(26'h0001000, k, r, e);
        chk_near("pin_2p0_res", r, 1419, 3);
        chk("pin_2p0_lat", k, 25);
        model(26'h00015BF, k, r, e);
        chk_near("pin_e_res", r, 2048, 3);
        model(26'h2000000, k, r, e);
        chk_near("pin_16384_res", r, 19874, 3);
        chk("pin_16384_lat", k, 12);
        model(26'h0000400, k, r, e);
        chk("pin_half_err", e, 1);
        chk("pin_half_lat", k, 1);

        foreach (dir_x[j]) begin
            pulse_start(dir_x[j]);
            wait_idle("directed_timeout");
        end

        // second start during busy must be dropped
        pulse_start(26'h0001000);
        repeat (5) @(posedge clk);
        #1 start = 1'b1;
        x = 26'h2000000;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle("busy_start_timeout");

        // start held through the whole operation, including the DONE cycle
        @(posedge clk);
        #1 x = 26'h2000000;
        start = 1'b1;
        repeat (13) @(posedge clk);
        #1 start = 1'b0;
        wait_idle("held_start_timeout");

        // reset in the middle of ITER
        pulse_start(26'h0001000);
        repeat (16) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        pulse_start(26'h0001000);
        wait_idle("post_reset_timeout");

        for (int n = 0; n < 150; n++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            w = $urandom_range(10, 26);
            rx = 26'($urandom) & 26'((64'd1 << w) - 1);
            pulse_start(rx);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 10)) @(posedge clk);
                #1 start = 1'b1;
                x = 26'($urandom);
                @(posedge clk);
                #1 start = 1'b0;
            end
            wait_idle("random_timeout");
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
